// File: rtl/dpcd_pkg.sv
// Shared types and special division codes for the divider ramp controller.
package dpcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    JUMP = 2'd1,
    RAMP = 2'd2
  } dpcd_ramp_state_t;

  // Codes 0/1 select bypass and inverted-clock modes; never used as ramp steps.
  localparam int unsigned DPCD_CODE_BYPASS = 0;
  localparam int unsigned DPCD_CODE_INVERT = 1;

endpackage

// File: rtl/dpcd_dwell_cnt.sv
// Loadable down-counter with zero flag; sets how long each ramp code is held.
module dpcd_dwell_cnt #(
  parameter int DWELL_W_P = 8
) (
  input  logic                 clk_divided,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [DWELL_W_P-1:0] load_val,
  input  logic                 dec,
  output logic                 zero
);

  logic [DWELL_W_P-1:0] cnt;

  always_ff @(posedge clk_divided or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (load)           cnt <= load_val;
    else if (dec && !zero)   cnt <= cnt - DWELL_W_P'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/dpcd_ramp_ctrl.sv
// Steps the divider code toward a requested target one code per dwell period,
// jumping directly only when the bypass/invert codes are involved.
module dpcd_ramp_ctrl
  import dpcd_pkg::*;
#(
  parameter int DIV_CTRL_SIZE_P = 4,
  parameter int DWELL_W_P       = 8,
  parameter int RESET_DIV_P     = 0
) (
  input  logic                       clk_divided,
  input  logic                       rst_n,
  input  logic                       tgt_valid,
  output logic                       tgt_ready,
  input  logic [DIV_CTRL_SIZE_P-1:0] tgt_div,
  input  logic [DWELL_W_P-1:0]       dwell_cycles,
  input  logic                       abort,
  output logic [DIV_CTRL_SIZE_P-1:0] div_ctrl,
  output logic                       busy,
  output logic                       done
);

  localparam logic [DIV_CTRL_SIZE_P-1:0] CODE_INV = DIV_CTRL_SIZE_P'(DPCD_CODE_INVERT);
  localparam logic [DIV_CTRL_SIZE_P-1:0] CODE_RST = DIV_CTRL_SIZE_P'(RESET_DIV_P);

  dpcd_ramp_state_t state, state_nxt;

  logic [DIV_CTRL_SIZE_P-1:0] tgt_q, div_nxt, step;
  logic [DWELL_W_P-1:0]       dwell_q, cnt_val;
  logic                       done_nxt, tgt_ld, cnt_ld, cnt_dec, cnt_zero, jump_cond;

  dpcd_dwell_cnt #(.DWELL_W_P(DWELL_W_P)) u_dwell (
    .clk_divided (clk_divided),
    .rst_n       (rst_n),
    .load        (cnt_ld),
    .load_val    (cnt_val),
    .dec         (cnt_dec),
    .zero        (cnt_zero)
  );

  assign busy      = (state != IDLE);
  assign tgt_ready = !busy;

  // Special codes on either end, or no distance to cover, go straight through JUMP.
  assign jump_cond = (tgt_div <= CODE_INV) || (div_ctrl <= CODE_INV) || (tgt_div == div_ctrl);
  assign step      = (tgt_q > div_ctrl) ? div_ctrl + DIV_CTRL_SIZE_P'(1)
                                        : div_ctrl - DIV_CTRL_SIZE_P'(1);

  always_ff @(posedge clk_divided or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      div_ctrl <= CODE_RST;
      done     <= 1'b0;
      tgt_q    <= '0;
      dwell_q  <= '0;
    end else begin
      state    <= state_nxt;
      div_ctrl <= div_nxt;
      done     <= done_nxt;
      if (tgt_ld) begin
        tgt_q   <= tgt_div;
        dwell_q <= dwell_cycles;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    div_nxt   = div_ctrl;
    done_nxt  = 1'b0;
    tgt_ld    = 1'b0;
    cnt_ld    = 1'b0;
    cnt_dec   = 1'b0;
    cnt_val   = dwell_q;
    case (state)
      IDLE: begin
        if (tgt_valid) begin
          tgt_ld = 1'b1;
          if (jump_cond) begin
            state_nxt = JUMP;
          end else begin
            state_nxt = RAMP;
            cnt_ld    = 1'b1;
            cnt_val   = dwell_cycles;
          end
        end
      end
      JUMP: begin
        state_nxt = IDLE;
        if (!abort) begin
          div_nxt  = tgt_q;
          done_nxt = 1'b1;
        end
      end
      RAMP: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (cnt_zero) begin
          div_nxt = step;
          cnt_ld  = 1'b1;
          if (step == tgt_q) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/dpcd_ramp_ctrl.md
# dpcd_ramp_ctrl

Control-side companion to the dynamic programmable clock divider. It accepts a target division code over a valid/ready handshake and drives the divider's `div_ctrl` input. It moves `div_ctrl` toward the target one code at a time, holding each code for a programmable number of divided-clock cycles, so the generated frequency never jumps abruptly. It runs on the divider's own output clock, so every code change lands on a divided-clock edge and is sampled glitch-free by the divider one edge later.

## Interface
Parameters:
- `DIV_CTRL_SIZE_P`, default 4: width of division code; must match the divider instance.
- `DWELL_W_P`, default 8: width of the dwell count.
- `RESET_DIV_P`, default 0: `div_ctrl` value while in reset (0 = divider bypass).

Ports:
- `clk_divided`  in  1  clock: divided clock produced by the divider.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `tgt_valid`  in  1  target code offered.
- `tgt_ready`  out  1  block can accept a target.
- `tgt_div`  in  DIV_CTRL_SIZE_P  requested division code.
- `dwell_cycles`  in  DWELL_W_P  extra `clk_divided` cycles to hold each intermediate code; sampled at accept.
- `abort`  in  1  stop the ramp and keep the current code.
- `div_ctrl`  out  DIV_CTRL_SIZE_P  code driven to the divider.
- `busy`  out  1  a ramp or jump is in progress.
- `done`  out  1  one-cycle pulse when `div_ctrl` reaches the target.

## Operation
- States: IDLE, JUMP, RAMP.
- Reset values:
  - state = IDLE
  - `div_ctrl` = RESET_DIV_P
  - `tgt_ready` = 1
  - `busy` = 0
  - `done` = 0
  - dwell counter = 0
- IDLE:
  - `tgt_ready` = 1.
  - On `tgt_valid && tgt_ready`, latch `tgt_div` into the target register and `dwell_cycles` into the dwell register.
  - Go to JUMP if any of these hold: target < 2, current `div_ctrl` < 2, or target == `div_ctrl`.
  - Otherwise go to RAMP and load the counter with `dwell_cycles`.
- Why JUMP exists: codes 0 and 1 are the special bypass and inverted-clock modes. They are never used as intermediate ramp steps, only reached or left by a direct jump.
- JUMP (exactly one cycle): set `div_ctrl` to the target, pulse `done`, return to IDLE.
- RAMP, evaluated each cycle:
  - Counter ≠ 0: decrement the counter.
  - Counter == 0: step `div_ctrl` by +1 if target > `div_ctrl`, else by −1, then reload the counter from the dwell register.
  - If the stepped value equals the target: pulse `done` and go to IDLE.
- Comparisons are unsigned at DIV_CTRL_SIZE_P width. Steps never wrap, because the ramp stops when it reaches the target.
- `busy` is 1 whenever state ≠ IDLE. `tgt_ready` = !`busy`. `tgt_valid` is ignored while busy.
- `abort`:
  - In RAMP or JUMP it has priority over stepping and the counter. The next state is IDLE, `div_ctrl` holds its current value, and `done` is not pulsed.
  - In IDLE, `abort` is ignored, and acceptance of a target proceeds normally.
- `done` is registered; it is high in the same cycle the final `div_ctrl` value first appears.

## Timing
- Let accept occur at edge k.
- JUMP path: `div_ctrl` = target and `done` = 1 after edge k+1. `tgt_ready` returns to 1 after edge k+1.
- RAMP path: step n occurs at edge k + n·(dwell_cycles+1).
  - With dwell_cycles = 0, the code changes on every edge.
  - The final step coincides with `done` = 1. `busy` falls after that same edge.
- The divider samples `div_ctrl` on the next `clk_divided` rising edge, so the frequency change trails each `div_ctrl` update by one edge.
- Async reset mid-ramp: all outputs return to their reset values immediately. The pending target is discarded.
- Inputs must be synchronous to `clk_divided`. Crossing into this domain is the caller's responsibility.

## Structure
- Package `dpcd_pkg` holds:
  - the state enum `dpcd_ramp_state_t` (IDLE, JUMP, RAMP);
  - the constants for the special codes, `DPCD_CODE_BYPASS` = 0 and `DPCD_CODE_INVERT` = 1.
- One sub-module, `dpcd_dwell_cnt`: a loadable down-counter with a zero flag, DWELL_W_P wide.
- Everything else lives in `dpcd_ramp_ctrl`.

## Test plan
- Reset with RESET_DIV_P = 0:
  - `div_ctrl` = 0, `busy` = 0, `tgt_ready` = 1, `done` = 0.
  - Assert `rst_n` low mid-ramp: the outputs return to these values asynchronously.
- Ramp up, from code 4 to target 9 with dwell 2: `div_ctrl` steps 5, 6, 7, 8, 9 at edges k+3, k+6, k+9, k+12, k+15. `done` is high only after edge k+15.
- Ramp down, from 12 to 6 with dwell 0: one step per edge, reaching 6 at edge k+6. During the ramp `tgt_ready` = 0, and a second `tgt_valid` is ignored.
- Jump cases:
  - From 7 to target 1: `div_ctrl` = 1 and `done` = 1 after edge k+1.
  - From 0 to target 10: direct jump to 10 after edge k+1.
  - From 5 to target 5: `done` after edge k+1, `div_ctrl` unchanged.
- Abort: during a ramp from 3 to 15 with dwell 1, assert `abort` when `div_ctrl` = 6. `div_ctrl` holds at 6, there is no `done`, `busy` = 0 on the next cycle, and the next target is accepted normally.
- Integration with the divider: ramp `div_ctrl` from 2 to 8 with dwell 3. The `clk_divided` period tracks each code change one edge after the update, with no runt pulses.
